// File: rtl/alu_pkg.sv
// Shared types for the pipelined integer ALU functional unit: opcode
// enumeration and the opcode-legality helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SRA  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SRL  = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    localparam int unsigned ALU_NUM_OPS = 10;

    function automatic logic alu_op_legal(input logic [3:0] op);
        return (32'(op) < ALU_NUM_OPS);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (a, b, op) -> (result, cout, illegal).
// Undefined opcodes produce a zero result with no carry.
module alu_core
    import alu_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int SHW      = $clog2(BITWIDTH)
) (
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    input  logic [3:0]          op,
    output logic [BITWIDTH-1:0] result,
    output logic                cout,
    output logic                illegal
);

    logic [BITWIDTH:0] sum;
    logic [BITWIDTH:0] diff;
    logic [SHW-1:0]    shamt;
    logic              lt_signed;
    logic              lt_unsigned;

    // SUB is A + ~B + 1 so its carry out reads as "no borrow".
    assign sum         = {1'b0, a} + {1'b0, b};
    assign diff        = {1'b0, a} + {1'b0, ~b} + {{BITWIDTH{1'b0}}, 1'b1};
    assign shamt       = b[SHW-1:0];
    assign lt_signed   = ($signed(a) < $signed(b));
    assign lt_unsigned = (a < b);

    always_comb begin
        result  = '0;
        cout    = 1'b0;
        illegal = !alu_op_legal(op);
        case (op)
            OP_ADD:  begin result = sum[BITWIDTH-1:0];  cout = sum[BITWIDTH];  end
            OP_SUB:  begin result = diff[BITWIDTH-1:0]; cout = diff[BITWIDTH]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_SRL:  result = a >> shamt;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(BITWIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: result = {{(BITWIDTH-1){1'b0}}, lt_unsigned};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe_fu.sv
// Pipelined ALU functional unit: compute in stage 1, pure delay registers
// behind it, valid/ready on both sides with collapsing bubbles and flush.
module alu_pipe_fu
    import alu_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int TAGWIDTH = 6,
    parameter int NSTAGES  = 2,
    parameter int SHW      = $clog2(BITWIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_op,
    input  logic [BITWIDTH-1:0] in_a,
    input  logic [BITWIDTH-1:0] in_b,
    input  logic [TAGWIDTH-1:0] in_tag,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_result,
    output logic [TAGWIDTH-1:0] out_tag,
    output logic                out_zero,
    output logic                out_cout,
    output logic                out_illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; the producer holds its payload stable while valid && !ready.
    typedef struct packed {
        logic                valid;
        logic [BITWIDTH-1:0] result;
        logic [TAGWIDTH-1:0] tag;
        logic                zero;
        logic                cout;
        logic                illegal;
    } alu_stage_t;

    logic [BITWIDTH-1:0] core_result;
    logic                core_cout;
    logic                core_illegal;
    alu_stage_t          stage_in;
    alu_stage_t          stage_q [NSTAGES];
    logic [NSTAGES-1:0]  adv;

    alu_core #(
        .BITWIDTH (BITWIDTH),
        .SHW      (SHW)
    ) u_core (
        .a       (in_a),
        .b       (in_b),
        .op      (in_op),
        .result  (core_result),
        .cout    (core_cout),
        .illegal (core_illegal)
    );

    // A stage may load when it is empty or its occupant moves on this cycle;
    // walking from the output back lets bubbles collapse under back-pressure.
    always_comb begin
        logic downstream;
        adv        = '0;
        downstream = out_ready;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            adv[k]     = !stage_q[k].valid || downstream;
            downstream = adv[k];
        end
    end

    assign in_ready = adv[0] && !flush;

    always_comb begin
        stage_in         = '0;
        stage_in.valid   = in_valid && in_ready;
        stage_in.result  = core_result;
        stage_in.tag     = in_tag;
        stage_in.zero    = (core_result == '0);
        stage_in.cout    = core_cout;
        stage_in.illegal = core_illegal;
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        alu_stage_t q;
        alu_stage_t d;

        if (k == 0) begin : g_first
            assign d = stage_in;
        end else begin : g_rest
            assign d = stage_q[k-1];
        end

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                q <= '0;
            end else if (adv[k]) begin
                q <= d;
            end
        end

        assign stage_q[k] = q;
    end

    assign out_valid   = stage_q[NSTAGES-1].valid;
    assign out_result  = stage_q[NSTAGES-1].result;
    assign out_tag     = stage_q[NSTAGES-1].tag;
    assign out_zero    = stage_q[NSTAGES-1].zero;
    assign out_cout    = stage_q[NSTAGES-1].cout;
    assign out_illegal = stage_q[NSTAGES-1].illegal;

endmodule

// File: tb/tb_alu_pipe_fu.sv
// Directed bench for alu_pipe_fu: reset, streaming, compares/shifts,
// back-pressure, flush and illegal-op latency at NSTAGES = 1, 2 and 4.
module tb_alu_pipe_fu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [5:0]  in_tag;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  out_valid,  out_zero,  out_cout,  out_illegal;
    logic [31:0] out_result;
    logic [5:0]  out_tag;
    logic        r1_in_ready, r1_out_valid, r1_zero, r1_cout, r1_illegal;
    logic [31:0] r1_result;
    logic [5:0]  r1_tag;
    logic        r4_in_ready, r4_out_valid, r4_zero, r4_cout, r4_illegal;
    logic [31:0] r4_result;
    logic [5:0]  r4_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_pipe_fu #(.BITWIDTH(32), .TAGWIDTH(6), .NSTAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_zero(out_zero), .out_cout(out_cout),
        .out_illegal(out_illegal)
    );

    alu_pipe_fu #(.BITWIDTH(32), .TAGWIDTH(6), .NSTAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(r1_out_valid), .out_ready(1'b1), .out_result(r1_result),
        .out_tag(r1_tag), .out_zero(r1_zero), .out_cout(r1_cout),
        .out_illegal(r1_illegal)
    );

    alu_pipe_fu #(.BITWIDTH(32), .TAGWIDTH(6), .NSTAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(r4_out_valid), .out_ready(1'b1), .out_result(r4_result),
        .out_tag(r4_tag), .out_zero(r4_zero), .out_cout(r4_cout),
        .out_illegal(r4_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic chk_out(input string name, input vec_t e);
        chk({name, "_valid"},   64'(out_valid),   64'(1'b1));
        chk({name, "_result"},  64'(out_result),  64'(e.res));
        chk({name, "_tag"},     64'(out_tag),     64'(e.tag));
        chk({name, "_zero"},    64'(out_zero),    64'(e.zero));
        chk({name, "_cout"},    64'(out_cout),    64'(e.cout));
        chk({name, "_illegal"}, 64'(out_illegal), 64'(e.ill));
    endtask

    // Issues every queued vector back to back with out_ready high and checks
    // each result exactly two cycles after its issue cycle.
    task automatic run_stream(input string name);
        int n;
        n = vecs.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i < n) drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            else       drive(1'b0, 4'd0, 32'd0, 32'd0, 6'd0);
            @(negedge clk);
            if (i < n) chk({name, "_in_ready"}, 64'(in_ready), 64'(1'b1));
            if (i >= 2 && i < n + 2) chk_out($sformatf("%s%0d", name, i - 2), vecs[i-2]);
            else chk({name, "_idle"}, 64'(out_valid), 64'(1'b0));
            next_cycle();
        end
        vecs.delete();
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd1, 6'd1);

        // Reset held 3 cycles with a valid op presented.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
            next_cycle();
        end
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 6'd0);
        @(negedge clk);
        chk("rst_in_ready",    64'(in_ready),    64'(1'b1));
        chk("rst_out_valid2",  64'(out_valid),   64'(1'b0));
        chk("rst_out_result",  64'(out_result),  64'(32'd0));
        chk("rst_out_tag",     64'(out_tag),     64'(6'd0));
        chk("rst_out_zero",    64'(out_zero),    64'(1'b0));
        chk("rst_out_cout",    64'(out_cout),    64'(1'b0));
        chk("rst_out_illegal", 64'(out_illegal), 64'(1'b0));
        next_cycle();

        // Streaming: wrap-around ADD, borrowing SUB, sign-filling SRA.
        vecs.push_back('{OP_ADD, 32'hFFFF_FFFF, 32'd1, 6'd5, 32'h0000_0000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{OP_SUB, 32'd3,         32'd5, 6'd6, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SRA, 32'h8000_0000, 32'd4, 6'd7, 32'hF800_0000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SUB, 32'd9,         32'd9, 6'd8, 32'h0000_0000, 1'b1, 1'b1, 1'b0});
        run_stream("stream");

        // Compares and shifts; SLL uses only the low 5 bits of B.
        vecs.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'd1,     6'd8,  32'd1,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'd1,     6'd9,  32'd0,  1'b1, 1'b0, 1'b0});
        vecs.push_back('{OP_SLL,  32'd1,         32'h25,    6'd10, 32'h20, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_SRL,  32'h8000_0000, 32'd31,    6'd11, 32'd1,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{OP_XOR,  32'hA5A5_0000, 32'h00FF_00FF, 6'd12, 32'hA55A_00FF, 1'b0, 1'b0, 1'b0});
        run_stream("cmpshift");

        // Back-pressure: two ops fill the pipe, the third waits.
        out_ready = 1'b0;
        drive(1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 6'd20);
        @(negedge clk);
        chk("bp_ready0", 64'(in_ready), 64'(1'b1));
        next_cycle();
        drive(1'b1, OP_OR, 32'h0000_000F, 32'h0000_00F0, 6'd21);
        @(negedge clk);
        chk("bp_ready1", 64'(in_ready), 64'(1'b1));
        next_cycle();
        drive(1'b1, OP_XOR, 32'h0000_00FF, 32'h0000_000F, 6'd22);
        @(negedge clk);
        chk("bp_ready2",  64'(in_ready),   64'(1'b0));
        chk("bp_hold_v",  64'(out_valid),  64'(1'b1));
        chk("bp_hold_r",  64'(out_result), 64'(32'h0000_F000));
        chk("bp_hold_t",  64'(out_tag),    64'(6'd20));
        next_cycle();
        @(negedge clk);
        chk("bp_ready3",   64'(in_ready),   64'(1'b0));
        chk("bp_stable_r", 64'(out_result), 64'(32'h0000_F000));
        chk("bp_stable_t", 64'(out_tag),    64'(6'd20));
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready4", 64'(in_ready), 64'(1'b1));
        chk_out("bp_first", '{OP_AND, 32'd0, 32'd0, 6'd20, 32'h0000_F000, 1'b0, 1'b0, 1'b0});
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 6'd0);
        @(negedge clk);
        chk_out("bp_second", '{OP_OR, 32'd0, 32'd0, 6'd21, 32'h0000_00FF, 1'b0, 1'b0, 1'b0});
        next_cycle();
        @(negedge clk);
        chk_out("bp_third", '{OP_XOR, 32'd0, 32'd0, 6'd22, 32'h0000_00F0, 1'b0, 1'b0, 1'b0});
        next_cycle();
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'(1'b0));

        // Flush with two ops in flight and a third presented.
        next_cycle();
        drive(1'b1, OP_ADD, 32'd1, 32'd2, 6'd30);
        next_cycle();
        drive(1'b1, OP_ADD, 32'd3, 32'd4, 6'd31);
        next_cycle();
        drive(1'b1, OP_ADD, 32'd5, 32'd6, 6'd32);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", 64'(in_ready),  64'(1'b0));
        chk("fl_out_v",    64'(out_valid), 64'(1'b1));
        chk("fl_out_t",    64'(out_tag),   64'(6'd30));
        next_cycle();
        flush = 1'b0;
        drive(1'b1, OP_ADD, 32'd10, 32'd20, 6'd33);
        @(negedge clk);
        chk("fl_after0", 64'(out_valid), 64'(1'b0));
        chk("fl_ready",  64'(in_ready),  64'(1'b1));
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 6'd0);
        @(negedge clk);
        chk("fl_after1", 64'(out_valid), 64'(1'b0));
        next_cycle();
        @(negedge clk);
        chk_out("fl_new", '{OP_ADD, 32'd0, 32'd0, 6'd33, 32'd30, 1'b0, 1'b0, 1'b0});
        next_cycle();
        @(negedge clk);
        chk("fl_drained", 64'(out_valid), 64'(1'b0));
        next_cycle();

        // Illegal opcode through NSTAGES = 1, 2 and 4.
        drive(1'b1, 4'hC, 32'd5, 32'd7, 6'd3);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 6'd0);
        @(negedge clk);
        chk("ill1_valid",   64'(r1_out_valid), 64'(1'b1));
        chk("ill1_illegal", 64'(r1_illegal),   64'(1'b1));
        chk("ill1_result",  64'(r1_result),    64'(32'd0));
        chk("ill1_zero",    64'(r1_zero),      64'(1'b1));
        chk("ill1_cout",    64'(r1_cout),      64'(1'b0));
        chk("ill1_tag",     64'(r1_tag),       64'(6'd3));
        chk("ill2_early",   64'(out_valid),    64'(1'b0));
        next_cycle();
        @(negedge clk);
        chk_out("ill2", '{4'hC, 32'd0, 32'd0, 6'd3, 32'd0, 1'b1, 1'b0, 1'b1});
        chk("ill1_gone",  64'(r1_out_valid), 64'(1'b0));
        chk("ill4_early", 64'(r4_out_valid), 64'(1'b0));
        next_cycle();
        @(negedge clk);
        chk("ill4_early2", 64'(r4_out_valid), 64'(1'b0));
        next_cycle();
        @(negedge clk);
        chk("ill4_valid",   64'(r4_out_valid), 64'(1'b1));
        chk("ill4_illegal", 64'(r4_illegal),   64'(1'b1));
        chk("ill4_result",  64'(r4_result),    64'(32'd0));
        chk("ill4_zero",    64'(r4_zero),      64'(1'b1));
        chk("ill4_tag",     64'(r4_tag),       64'(6'd3));
        next_cycle();
        @(negedge clk);
        chk("ill4_gone", 64'(r4_out_valid), 64'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
